// File: rtl/serial_tx.sv
// serial_tx: idle-high serial frame transmitter with a valid/ready word input.
// Frame: start 0, data LSB first, optional even parity, stop 1; each bit is CLKS_PER_BIT clocks.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_WIDTH-1:0] sr, sr_n;
  logic par, par_n, serial_n, ready_n, busy_n, done_n, last;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      par       <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      sr        <= sr_n;
      par       <= par_n;
      tx_serial <= serial_n;
      tx_ready  <= ready_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
    end
  end
  // The shift register is pre-shifted as each bit is launched, so sr[0] is always the next bit.
  always_comb begin
    last     = cnt == CMAX;
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    sr_n     = sr;
    par_n    = par;
    serial_n = tx_serial;
    ready_n  = tx_ready;
    busy_n   = tx_busy;
    done_n   = 1'b0;
    if (state != IDLE) cnt_n = last ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n  = START;
        sr_n     = tx_data;
        par_n    = ^tx_data;
        cnt_n    = '0;
        serial_n = 1'b0;
        ready_n  = 1'b0;
        busy_n   = 1'b1;
      end
      START: if (last) begin
        state_n  = DATA;
        serial_n = sr[0];
        sr_n     = sr >> 1;
        bit_n    = '0;
      end
      DATA: if (last) begin
        if (bit_idx == BMAX) begin
          state_n  = PARITY_EN ? PARITY : STOP;
          serial_n = PARITY_EN ? par : 1'b1;
        end else begin
          bit_n    = bit_idx + 1'b1;
          serial_n = sr[0];
          sr_n     = sr >> 1;
        end
      end
      PARITY: if (last) begin
        state_n  = STOP;
        serial_n = 1'b1;
      end
      STOP: if (last) begin
        state_n = IDLE;
        done_n  = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and random frames on two serial_tx instances against a waveform model.
module tb_serial_tx;
  logic clk = 1'b0, reset;
  logic [7:0] d0, d1;
  logic v0, v1, r0, r1, s0, s1, b0, b1, k0, k1;
  int checks = 0, errors = 0;
  bit exp_q[$];
  serial_tx dut0 (
    .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .tx_serial(s0), .tx_busy(b0), .tx_done(k0)
  );
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx_serial(s1), .tx_busy(b1), .tx_done(k1)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  // Returns {serial, ready, busy, done} of the selected instance.
  function automatic logic [3:0] outs(input bit w);
    return w ? {s1, r1, b1, k1} : {s0, r0, b0, k0};
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected line level for every clock of the frame, built bit by bit from the frame rules.
  function automatic void build(input logic [7:0] d, input int cpb, input bit pe);
    bit bits[$];
    exp_q.delete();
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (pe) bits.push_back(bit'($countones(d) % 2));
    bits.push_back(1'b1);
    foreach (bits[j]) for (int c = 0; c < cpb; c++) exp_q.push_back(bits[j]);
  endfunction
  task automatic drive(input bit w, input logic [7:0] d, input logic v);
    if (w) begin d1 = d; v1 = v; end else begin d0 = d; v0 = v; end
  endtask
  // Called #1 after an edge with the instance idle; returns #1 after the done edge (or one cycle later).
  task automatic run_frame(input bit w, input logic [7:0] d, input bit hold, input bit noise,
                           input logic [7:0] post_d);
    chk("pre_ready", outs(w) & 4'b0100, 4'b0100);
    build(d, w ? 1 : 4, !w);
    drive(w, d, 1'b1);
    @(posedge clk); #1;
    drive(w, hold ? post_d : 8'($urandom), hold);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (noise) drive(w, 8'($urandom), 1'($urandom));
      chk($sformatf("frame_%0h_cyc%0d", d, i), outs(w), {exp_q[i], 3'b010});
      @(posedge clk); #1;
    end
    drive(w, hold ? post_d : 8'h00, hold);
    chk("done_pulse", outs(w), 4'b1101);
    if (!hold) begin
      @(posedge clk); #1;
      chk("after_done", outs(w), 4'b1100);
    end
  endtask
  initial begin
    reset = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", outs(0), 4'b1100);
    chk("reset1", outs(1), 4'b1100);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle0", outs(0), 4'b1100);
    end
    run_frame(0, 8'hA5, 0, 0, 8'h00);
    run_frame(0, 8'h01, 0, 0, 8'h00);
    run_frame(0, 8'hFF, 0, 0, 8'h00);
    run_frame(0, 8'h3C, 1, 0, 8'hFF);
    run_frame(0, 8'hFF, 0, 0, 8'h00);
    d0 = 8'h55;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("abort_start", outs(0), 4'b0010);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_async", outs(0), 4'b1100);
    @(posedge clk); #1;
    chk("abort_held", outs(0), 4'b1100);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", outs(0), 4'b1100);
    end
    run_frame(0, 8'h0F, 0, 0, 8'h00);
    run_frame(1, 8'h81, 0, 0, 8'h00);
    repeat (6) run_frame(0, 8'($urandom), 0, 1, 8'h00);
    repeat (4) run_frame(1, 8'($urandom), 0, 1, 8'h00);
    run_frame(1, 8'h5A, 1, 0, 8'hC3);
    run_frame(1, 8'hC3, 0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
